// File: rtl/axi_rd_burst_gen_pkg.sv
// Shared definitions for the AXI read burst generator: AXI encodings,
// the engine state encoding and the burst-length helper.
package axi_rd_burst_gen_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // AXI bursts must not cross a 4 KB address boundary.
    localparam int AXI_BOUNDARY_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Length of the next burst in beats: the smallest of the beats still to
    // request, the burst cap, and the beats left before the next 4 KB boundary.
    function automatic logic [8:0] calc_burst_len(
        input logic [31:0] remaining,
        input logic [11:0] addr_lo,
        input logic [31:0] max_len,
        input logic [31:0] bytes_per_beat
    );
        logic [31:0] to_boundary;
        logic [31:0] len;
        to_boundary = (32'(AXI_BOUNDARY_BYTES) - {20'd0, addr_lo}) / bytes_per_beat;
        len = remaining;
        if (len > max_len) begin
            len = max_len;
        end
        if (len > to_boundary) begin
            len = to_boundary;
        end
        return 9'(len);
    endfunction

endpackage

// File: rtl/axi_rd_burst_gen.sv
// Per-port AXI4 read request engine: splits one transfer request into INCR
// bursts, bounds the number of outstanding bursts, streams R beats into the
// read buffer under its back-pressure and pulses rx_done when all beats landed.
module axi_rd_burst_gen
    import axi_rd_burst_gen_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int TX_SIZE_WIDTH   = 10,
    parameter int MAX_BURST_LEN   = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      rx_req,
    input  logic [31:0]               rx_addr,
    input  logic [TX_SIZE_WIDTH-1:0]  rx_req_size,
    output logic                      rx_busy,
    output logic                      rx_done,
    output logic                      rd_err,

    output logic [31:0]               m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,

    input  logic                      rd_buf_full,
    output logic                      rd_buf_push,
    output logic [AXI_DATA_WIDTH-1:0] rd_buf_data
);

    localparam int BYTES     = AXI_DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);

    rd_state_e                 state_reg;
    rd_state_e                 state_next;

    logic [31:0]               next_addr_reg;
    logic [TX_SIZE_WIDTH-1:0]  addr_left_reg;
    logic [TX_SIZE_WIDTH-1:0]  beats_left_reg;
    logic [OUT_W-1:0]          outstanding_reg;
    logic                      arvalid_reg;
    logic [31:0]               araddr_reg;
    logic [7:0]                arlen_reg;
    logic                      rd_err_reg;
    logic                      zero_done_reg;

    logic                      accept;
    logic                      zero_req;
    logic                      ar_hs;
    logic                      rlast_push;
    logic [8:0]                cur_len;
    logic [8:0]                first_len;
    logic [8:0]                new_len;
    logic [31:0]               addr_after;
    logic [TX_SIZE_WIDTH-1:0]  left_after;
    logic [OUT_W-1:0]          out_after;
    logic                      drain_done;

    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arlen   = arlen_reg;
    assign m_axi_arsize  = 3'(SIZE_LOG2);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arvalid = arvalid_reg;
    assign rd_err        = rd_err_reg;
    assign rd_buf_data   = m_axi_rdata;

    // Request decode and the post-handshake view of the AR bookkeeping, so a
    // following burst can be presented in the cycle right after a handshake.
    always_comb begin
        accept     = (state_reg == ST_IDLE) && rx_req && (rx_req_size != '0);
        zero_req   = (state_reg == ST_IDLE) && rx_req && (rx_req_size == '0);
        ar_hs      = arvalid_reg && m_axi_arready;
        rlast_push = rd_buf_push && m_axi_rlast;
        cur_len    = 9'(arlen_reg) + 9'd1;
        addr_after = next_addr_reg;
        left_after = addr_left_reg;
        if (ar_hs) begin
            addr_after = next_addr_reg + (32'(cur_len) << SIZE_LOG2);
            left_after = addr_left_reg - TX_SIZE_WIDTH'(cur_len);
        end
        out_after  = outstanding_reg + OUT_W'(ar_hs) - OUT_W'(rlast_push);
        new_len    = calc_burst_len(32'(left_after), addr_after[11:0],
                                    32'(MAX_BURST_LEN), 32'(BYTES));
        first_len  = calc_burst_len(32'(rx_req_size), rx_addr[11:0],
                                    32'(MAX_BURST_LEN), 32'(BYTES));
        drain_done = (state_reg == ST_DRAIN) && (beats_left_reg == '0) &&
                     (outstanding_reg == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: issue bursts until all are requested, then drain beats.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: if (ar_hs && (left_after == '0)) state_next = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode: R path is combinational so beats pass with zero latency.
    always_comb begin
        rx_busy      = (state_reg != ST_IDLE);
        m_axi_rready = (state_reg != ST_IDLE) && !rd_buf_full;
        rd_buf_push  = m_axi_rvalid && m_axi_rready;
        rx_done      = drain_done || zero_done_reg;
    end

    // Datapath: address/beat counters, outstanding tracking, registered AR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            next_addr_reg   <= '0;
            addr_left_reg   <= '0;
            beats_left_reg  <= '0;
            outstanding_reg <= '0;
            arvalid_reg     <= 1'b0;
            araddr_reg      <= '0;
            arlen_reg       <= '0;
            rd_err_reg      <= 1'b0;
            zero_done_reg   <= 1'b0;
        end else begin
            zero_done_reg <= zero_req;
            if (accept) begin
                // Nothing is outstanding in IDLE, so the first burst goes out now.
                next_addr_reg  <= rx_addr;
                addr_left_reg  <= rx_req_size;
                beats_left_reg <= rx_req_size;
                rd_err_reg     <= 1'b0;
                arvalid_reg    <= 1'b1;
                araddr_reg     <= rx_addr;
                arlen_reg      <= 8'(first_len - 9'd1);
            end else if (state_reg != ST_IDLE) begin
                next_addr_reg   <= addr_after;
                addr_left_reg   <= left_after;
                outstanding_reg <= out_after;
                if (rd_buf_push) begin
                    beats_left_reg <= beats_left_reg - 1'b1;
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        rd_err_reg <= 1'b1;
                    end
                end
                // AR fields may only change when no request is pending.
                if ((state_reg == ST_ISSUE) && (ar_hs || !arvalid_reg)) begin
                    if ((left_after != '0) && (out_after < OUT_W'(MAX_OUTSTANDING))) begin
                        arvalid_reg <= 1'b1;
                        araddr_reg  <= addr_after;
                        arlen_reg   <= 8'(new_len - 9'd1);
                    end else begin
                        arvalid_reg <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
